pixel_compositor: RTL and testbench
===================================

# pixel_compositor

Final pixel stage of the video path. Consumes the 8-bit background palette index from the background controller and the sprite palette indices from the Fireboy/Icegirl sprite stages. Selects the visible index by priority, converts it to 24-bit RGB through a fixed palette, applies a frame-stepped fade for level transitions, and drives the VGA colour and sync outputs. VGA syncs are delayed so they stay aligned with the pixel data.

## Interface
- `FADE_STEPS`, 16: number of fade levels, one level per frame; must be a power of 2.
- `BLACK_FRAMES`, 30: frames held fully black between fade-out and fade-in.
- `Clk`  in  1  pixel clock, shared with the background controller.
- `Reset`  in  1  synchronous, active-high.
- `VGA_HS_in`, `VGA_VS_in`, `VGA_BLANK_N_in`  in  1 each  timing from the VGA controller, aligned with DrawX/DrawY (stage 0).
- `bg_data`  in  8  background index, valid 1 cycle after its DrawX/DrawY (stage 1).
- `fire_data`, `ice_data`  in  8 each  sprite indices, stage 1; `TRANSPARENT_IDX` (0) means no sprite.
- `level_event`  in  1  one-cycle pulse requesting a level transition.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  output colour.
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_N`  out  1 each  delayed syncs.
- `fade_busy`  out  1  high in any state other than NORMAL.
- `swap_level`  out  1  one-cycle pulse on entry to BLACK; the game loads the next level on this pulse.

## Operation
- Priority: `fire_data` if it is not transparent, else `ice_data` if it is not transparent, else `bg_data`. The background is always opaque.
- Palette: `PALETTE[0:15]` holds 24-bit RGB. Any index ≥16 maps to `DEBUG_RGB` (FF00FF).
- Blanking: when the delayed blank is 0, the palette-stage RGB is forced to 000000.
- Fade: `lvl` ranges 0..FADE_STEPS.
  - Each channel is computed as `out = (c * (FADE_STEPS - lvl)) >> log2(FADE_STEPS)`, using a 13-bit unsigned intermediate.
  - `lvl` = 0 passes the colour unchanged; `lvl` = FADE_STEPS gives 0.
- Frame tick: one-cycle pulse on a detected falling edge of `VGA_VS_in`. The previous VS value is registered.
- FSM (`fade_fsm`):
  - NORMAL: `lvl` = 0. `level_event` → FADE_OUT.
  - FADE_OUT: `lvl` increments on each tick. When the tick would make `lvl` reach FADE_STEPS → BLACK, `lvl` = FADE_STEPS, `swap_level` asserted for 1 cycle.
  - BLACK: a frame counter counts ticks. On the BLACK_FRAMES-th tick → FADE_IN.
  - FADE_IN: `lvl` decrements on each tick. When it reaches 0 → NORMAL.
- `level_event` is ignored outside NORMAL.
- A `level_event` and a tick in the same cycle in NORMAL enters FADE_OUT with `lvl` = 0; the first increment happens on the next tick.
- `lvl` changes only on the tick, so it is constant across each visible frame.

## Timing
- Pipeline: stage 0 is DrawX/syncs; stage 1 is the indices; stage 2 is the selected index; stage 3 is the palette RGB; the output register holds the faded RGB.
- Latency: RGB and syncs at the outputs correspond to the DrawX/DrawY presented 3 cycles earlier.
- Syncs pass through a 3-deep delay line, so they stay aligned exactly with RGB.
- Throughput: 1 pixel per clock, with no stalls.
- Reset (including mid-fade): all outputs take their reset values on the next edge.
  - RGB = 0, `VGA_HS` = `VGA_VS` = 1, `VGA_BLANK_N` = 0.
  - `fade_busy` = 0, `swap_level` = 0.
  - FSM = NORMAL, `lvl` = 0, frame counter = 0, delay lines cleared (HS/VS to 1, blank to 0), previous-VS register = 1.

## Structure
- `compositor_pkg` contains:
  - `TRANSPARENT_IDX`
  - the `PALETTE` constant array
  - `DEBUG_RGB`
  - enum `fade_state_t` {NORMAL, FADE_OUT, BLACK, FADE_IN}
- One sub-module, `fade_fsm`. It contains the VS edge detect, FSM, `lvl` and the frame counter, and outputs `lvl`, `fade_busy` and `swap_level`.
- The pipeline and the scaling multiply stay in `pixel_compositor`.

## Test plan
- Priority: blank_n = 1, bg = 4, fire = 0, ice = 7 → output is `PALETTE[7]` 3 cycles later. With fire = 2 → `PALETTE[2]`. With both sprites at 0 → `PALETTE[4]`.
- Sync alignment: toggle `VGA_HS_in` at cycle n → `VGA_HS` toggles at n+3. Blank_n = 0 with bg = 4 → RGB = 000000.
- Out-of-range index: bg = 200 → RGB = FF00FF.
- Fade sequence: `level_event`, then 16 VS falling edges.
  - → `swap_level` is a single pulse after the 16th edge.
  - → RGB = 000000.
  - → after 30 more edges the fade-in starts.
  - → after 16 more edges `fade_busy` = 0.
  - With a pixel of FFFFFF and `lvl` = 8 → 7F7F7F.
- Ignored event: `level_event` during FADE_IN → no change in `lvl` or state.
- Reset mid-fade: assert `Reset` in BLACK → next edge: NORMAL, `fade_busy` = 0, RGB = 0, `VGA_HS` = `VGA_VS` = 1.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and constants for the pixel compositor: palette, transparency index and the
// fade state encoding.
package compositor_pkg;

   localparam logic [7:0]  TRANSPARENT_IDX = 8'd0;
   localparam logic [23:0] DEBUG_RGB       = 24'hFF00FF;

   localparam logic [23:0] PALETTE [0:15] = '{
      24'h000000, 24'hFFFFFF, 24'hFF4000, 24'hC02000,
      24'h208040, 24'h40A060, 24'h806040, 24'h00C0FF,
      24'h0060C0, 24'hFFD700, 24'h808080, 24'h404040,
      24'hC0C0C0, 24'h00FF00, 24'hFF0000, 24'h0000FF
   };

   typedef enum logic [1:0] {NORMAL, FADE_OUT, BLACK, FADE_IN} fade_state_t;

   // Indices past the palette show up as magenta so stray data is obvious on screen.
   function automatic logic [23:0] palette_lookup(input logic [7:0] idx);
      if (idx < 8'd16) return PALETTE[idx[3:0]];
      return DEBUG_RGB;
   endfunction

endpackage

// File: rtl/fade_fsm.sv
// Frame-stepped fade sequencer: VS falling-edge tick, fade level and black-hold frame counter.
module fade_fsm
   import compositor_pkg::*;
#(
   parameter int unsigned FADE_STEPS   = 16,
   parameter int unsigned BLACK_FRAMES = 30,
   localparam int unsigned LvlW        = $clog2(FADE_STEPS + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            vs_i,
   input  logic            level_event_i,
   output logic [LvlW-1:0] lvl_o,
   output logic            fade_busy_o,
   output logic            swap_level_o
);

   localparam int unsigned CntW = $clog2(BLACK_FRAMES + 1);

   fade_state_t     state_q;
   logic [LvlW-1:0] lvl_q;
   logic [CntW-1:0] cnt_q;
   logic            vs_prev_q;
   logic            busy_q;
   logic            swap_q;
   logic            tick;

   assign tick = vs_prev_q & ~vs_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= NORMAL;
         lvl_q     <= '0;
         cnt_q     <= '0;
         vs_prev_q <= 1'b1;
         busy_q    <= 1'b0;
         swap_q    <= 1'b0;
      end else begin
         vs_prev_q <= vs_i;
         swap_q    <= 1'b0;
         unique case (state_q)
            NORMAL: begin
               // An event wins over a coincident tick; the first step waits for the next tick.
               lvl_q <= '0;
               if (level_event_i) begin
                  state_q <= FADE_OUT;
                  busy_q  <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (tick) begin
                  if (lvl_q == LvlW'(FADE_STEPS - 1)) begin
                     state_q <= BLACK;
                     lvl_q   <= LvlW'(FADE_STEPS);
                     cnt_q   <= '0;
                     swap_q  <= 1'b1;
                  end else begin
                     lvl_q <= lvl_q + LvlW'(1);
                  end
               end
            end
            BLACK: begin
               if (tick) begin
                  if (cnt_q == CntW'(BLACK_FRAMES - 1)) begin
                     state_q <= FADE_IN;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            end
            FADE_IN: begin
               if (tick) begin
                  lvl_q <= lvl_q - LvlW'(1);
                  if (lvl_q == LvlW'(1)) begin
                     state_q <= NORMAL;
                     busy_q  <= 1'b0;
                  end
               end
            end
            default: state_q <= NORMAL;
         endcase
      end
   end

   assign lvl_o        = lvl_q;
   assign fade_busy_o  = busy_q;
   assign swap_level_o = swap_q;

endmodule

// File: rtl/pixel_compositor.sv
// Final video stage: sprite/background priority select, palette lookup, fade scaling and
// sync delay so that colour and syncs leave together three cycles after DrawX/DrawY.
module pixel_compositor
   import compositor_pkg::*;
#(
   parameter int unsigned FADE_STEPS   = 16,
   parameter int unsigned BLACK_FRAMES = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       VGA_HS_in,
   input  logic       VGA_VS_in,
   input  logic       VGA_BLANK_N_in,
   input  logic [7:0] bg_data,
   input  logic [7:0] fire_data,
   input  logic [7:0] ice_data,
   input  logic       level_event,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       fade_busy,
   output logic       swap_level
);

   localparam int unsigned LvlW   = $clog2(FADE_STEPS + 1);
   localparam int unsigned ShiftW = $clog2(FADE_STEPS);
   localparam int unsigned ProdW  = 8 + LvlW;

   logic [2:0]      hs_dly_q, vs_dly_q, blank_dly_q;
   logic [7:0]      sel_d, sel_q;
   logic [23:0]     pal_rgb, rgb_d, rgb_q;
   logic [LvlW-1:0] lvl;

   fade_fsm #(
      .FADE_STEPS  (FADE_STEPS),
      .BLACK_FRAMES(BLACK_FRAMES)
   ) u_fade_fsm (
      .clk_i        (Clk),
      .rst_i        (Reset),
      .vs_i         (VGA_VS_in),
      .level_event_i(level_event),
      .lvl_o        (lvl),
      .fade_busy_o  (fade_busy),
      .swap_level_o (swap_level)
   );

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [LvlW-1:0] l);
      logic [ProdW-1:0] prod;
      prod = ProdW'(c) * ProdW'(LvlW'(FADE_STEPS) - l);
      return prod[ShiftW +: 8];
   endfunction

   always_comb begin
      sel_d = bg_data;
      if (fire_data != TRANSPARENT_IDX) begin
         sel_d = fire_data;
      end else if (ice_data != TRANSPARENT_IDX) begin
         sel_d = ice_data;
      end
   end

   // blank_dly_q[1] is aligned with sel_q, i.e. the pixel currently at the palette stage.
   always_comb begin
      pal_rgb = blank_dly_q[1] ? palette_lookup(sel_q) : 24'h000000;
      rgb_d   = {scale(pal_rgb[23:16], lvl), scale(pal_rgb[15:8], lvl), scale(pal_rgb[7:0], lvl)};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hs_dly_q    <= '1;
         vs_dly_q    <= '1;
         blank_dly_q <= '0;
         sel_q       <= TRANSPARENT_IDX;
         rgb_q       <= '0;
      end else begin
         hs_dly_q    <= {hs_dly_q[1:0], VGA_HS_in};
         vs_dly_q    <= {vs_dly_q[1:0], VGA_VS_in};
         blank_dly_q <= {blank_dly_q[1:0], VGA_BLANK_N_in};
         sel_q       <= sel_d;
         rgb_q       <= rgb_d;
      end
   end

   assign VGA_R       = rgb_q[23:16];
   assign VGA_G       = rgb_q[15:8];
   assign VGA_B       = rgb_q[7:0];
   assign VGA_HS      = hs_dly_q[2];
   assign VGA_VS      = vs_dly_q[2];
   assign VGA_BLANK_N = blank_dly_q[2];

endmodule

// File: tb/tb_pixel_compositor.sv
// Randomised scoreboard bench for pixel_compositor with a frame-count reference model of the fade.
module tb_pixel_compositor;

   localparam int FadeSteps   = 16;
   localparam int BlackFrames = 30;
   localparam int FadeTotal   = 2 * FadeSteps + BlackFrames;
   localparam int FramePeriod = 40;
   localparam int MaxCyc      = 12000;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       hs_in = 1'b1, vs_in = 1'b1, blank_in = 1'b0, level_event = 1'b0;
   logic [7:0] bg = '0, fire = '0, ice = '0;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_HS, VGA_VS, VGA_BLANK_N, fade_busy, swap_level;

   pixel_compositor #(
      .FADE_STEPS  (FadeSteps),
      .BLACK_FRAMES(BlackFrames)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .VGA_HS_in     (hs_in),
      .VGA_VS_in     (vs_in),
      .VGA_BLANK_N_in(blank_in),
      .bg_data       (bg),
      .fire_data     (fire),
      .ice_data      (ice),
      .level_event   (level_event),
      .VGA_R         (VGA_R),
      .VGA_G         (VGA_G),
      .VGA_B         (VGA_B),
      .VGA_HS        (VGA_HS),
      .VGA_VS        (VGA_VS),
      .VGA_BLANK_N   (VGA_BLANK_N),
      .fade_busy     (fade_busy),
      .swap_level    (swap_level)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int          tag;
      logic [23:0] rgb;
      logic        hs, vs, blank;
   } pix_t;

   pix_t sb_q[$];
   int   checks = 0, failures = 0;
   int   cyc = 0;
   int   swap_seen = 0;
   bit   rst_hist [MaxCyc];
   int   lvl_hist [MaxCyc];

   // Fade model: the level is a pure function of ticks counted since the accepted event.
   bit fading = 1'b0;
   int n_ticks = 0;
   bit prev_vs = 1'b1;
   bit swap_exp = 1'b0;

   function automatic int lvl_of(bit f, int n);
      if (!f) return 0;
      if (n <= FadeSteps) return n;
      if (n <= FadeSteps + BlackFrames) return FadeSteps;
      return FadeTotal - n;
   endfunction

   function automatic logic [23:0] pal_ref(logic [7:0] idx);
      case (idx)
         8'd0:  return 24'h000000;
         8'd1:  return 24'hFFFFFF;
         8'd2:  return 24'hFF4000;
         8'd3:  return 24'hC02000;
         8'd4:  return 24'h208040;
         8'd5:  return 24'h40A060;
         8'd6:  return 24'h806040;
         8'd7:  return 24'h00C0FF;
         8'd8:  return 24'h0060C0;
         8'd9:  return 24'hFFD700;
         8'd10: return 24'h808080;
         8'd11: return 24'h404040;
         8'd12: return 24'hC0C0C0;
         8'd13: return 24'h00FF00;
         8'd14: return 24'hFF0000;
         8'd15: return 24'h0000FF;
         default: return 24'hFF00FF;
      endcase
   endfunction

   function automatic logic [23:0] fade_ref(logic [23:0] c, int l);
      int r, g, b;
      r = int'(c[23:16]) * (FadeSteps - l) / FadeSteps;
      g = int'(c[15:8]) * (FadeSteps - l) / FadeSteps;
      b = int'(c[7:0]) * (FadeSteps - l) / FadeSteps;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   always @(posedge Clk) begin
      bit tick;
      if (cyc < MaxCyc) rst_hist[cyc] = Reset;
      swap_exp = 1'b0;
      if (Reset) begin
         fading  = 1'b0;
         n_ticks = 0;
         prev_vs = 1'b1;
      end else begin
         tick    = prev_vs && !vs_in;
         prev_vs = vs_in;
         if (!fading) begin
            if (level_event) begin
               fading  = 1'b1;
               n_ticks = 0;
            end
         end else if (tick) begin
            n_ticks++;
            if (n_ticks == FadeSteps) swap_exp = 1'b1;
            if (n_ticks == FadeTotal) fading = 1'b0;
         end
      end
      if (cyc < MaxCyc) lvl_hist[cyc] = lvl_of(fading, n_ticks);
      cyc++;
   end

   always @(negedge Clk) begin
      int          m;
      bit          has;
      pix_t        e;
      logic [31:0] expv;
      m = cyc;
      if (m >= 1 && m < MaxCyc) begin
         check("fade_busy", {31'b0, fade_busy}, {31'b0, fading});
         check("swap_level", {31'b0, swap_level}, {31'b0, swap_exp});
         if (swap_level) swap_seen++;
         while (sb_q.size() > 0 && sb_q[0].tag < m - 3) void'(sb_q.pop_front());
         has = (sb_q.size() > 0) && (sb_q[0].tag == m - 3);
         if (has) e = sb_q.pop_front();
         if (rst_hist[m-1] || (has && (rst_hist[m-3] || rst_hist[m-2]))) begin
            expv = {5'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
            check("pixel_reset", {5'b0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, expv);
         end else if (has) begin
            expv = {5'b0, fade_ref(e.rgb, lvl_hist[m-2]), e.hs, e.vs, e.blank};
            check("pixel", {5'b0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, expv);
         end
      end
   end

   logic       p_valid = 1'b0, p_hs, p_vs, p_blank;
   logic [7:0] p_bg, p_fire, p_ice;

   function automatic logic [7:0] rand_idx();
      if ($urandom_range(0, 9) == 0) return 8'($urandom_range(16, 255));
      return 8'($urandom_range(0, 15));
   endfunction

   // Drives syncs of pixel `cyc` and the indices of the previous pixel, then advances a cycle.
   task automatic step(bit rst, bit ev, bit dir, logic [7:0] dbg, logic [7:0] dfire,
                       logic [7:0] dice, bit dblank);
      int         c, p;
      logic       hs, vs, blank;
      logic [7:0] b, f, i, sel;
      pix_t       e;
      c     = cyc;
      p     = c % FramePeriod;
      hs    = (c % 8) != 0;
      vs    = p >= 2;
      blank = dir ? dblank : ((p >= 4) && ((c % 8) >= 2));
      b     = dir ? dbg : rand_idx();
      f     = dir ? dfire : (($urandom_range(0, 2) == 0) ? rand_idx() : 8'd0);
      i     = dir ? dice : (($urandom_range(0, 2) == 0) ? rand_idx() : 8'd0);
      Reset       = rst;
      level_event = ev;
      hs_in       = hs;
      vs_in       = vs;
      blank_in    = blank;
      if (p_valid) begin
         bg   = p_bg;
         fire = p_fire;
         ice  = p_ice;
         sel  = (p_fire != 8'd0) ? p_fire : ((p_ice != 8'd0) ? p_ice : p_bg);
         e.tag   = c - 1;
         e.rgb   = p_blank ? pal_ref(sel) : 24'h000000;
         e.hs    = p_hs;
         e.vs    = p_vs;
         e.blank = p_blank;
         sb_q.push_back(e);
      end
      p_valid = 1'b1;
      p_hs    = hs;
      p_vs    = vs;
      p_blank = blank;
      p_bg    = b;
      p_fire  = f;
      p_ice   = i;
      @(posedge Clk);
      #1;
   endtask

   task automatic rand_steps(int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
   endtask

   logic [7:0] d_bg    [7] = '{8'd4, 8'd4, 8'd4, 8'd4, 8'd200, 8'd4, 8'd1};
   logic [7:0] d_fire  [7] = '{8'd0, 8'd2, 8'd0, 8'd0, 8'd0,   8'd9, 8'd0};
   logic [7:0] d_ice   [7] = '{8'd7, 8'd7, 8'd0, 8'd0, 8'd0,   8'd0, 8'd0};
   bit         d_blank [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,   1'b1, 1'b1};

   initial begin
      bit sent;
      int guard;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1, d_bg[k], d_fire[k], d_ice[k], d_blank[k]);
      rand_steps(100);

      // First fade: event coincides with a VS falling edge; a second event lands in fade-in.
      for (int k = 0; k < FramePeriod && (cyc % FramePeriod) != 0; k++) rand_steps(1);
      swap_seen = 0;
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      sent  = 1'b0;
      guard = 0;
      while ((fading || fade_busy) && guard < 4000) begin
         if (!sent && fading && n_ticks == 50) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
            sent = 1'b1;
         end else begin
            rand_steps(1);
         end
         guard++;
      end
      rand_steps(2);
      check("fade1_busy_clear", {31'b0, fade_busy}, 32'd0);
      check("fade1_swap_pulses", swap_seen, 32'd1);
      rand_steps(50);

      // Second fade, reset while holding black.
      step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      guard = 0;
      while (n_ticks < 30 && guard < 3000) begin
         rand_steps(1);
         guard++;
      end
      check("fade2_reached_black", {31'b0, fade_busy}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      check("reset_busy", {31'b0, fade_busy}, 32'd0);
      check("reset_rgb_sync", {5'b0, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N},
            {5'b0, 24'h000000, 3'b110});
      rand_steps(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
